fusion_array_stream: RTL and testbench

- Next-generation Bit Fusion compute array: a ROWS x COLS grid of fusion_unit PEs in a weight-stationary dataflow.
- Adds what the plain array lacks: a weight-load state machine, per-row input skew, pipelined psums, valid/ready streaming with backpressure, and a frame last flag.
- Sits between the activation buffer (input stream) and the accumulator/output buffer (psum stream).

---
 rtl/fusion_array_stream.sv | 218 +++++++++++++++++++++
 tb/tb_fusion_array_stream.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fusion_array_stream.sv
// Weight-stationary ROWS x COLS fusion array: weight-load FSM, skewed row inputs,
// pipelined psums and a valid/ready stream with backpressure and a frame-last flag.

// Fusion PE product: each operand is the low in/weight-width bits (2, 4, else 8) of its
// byte, sign- or zero-extended per the signedness flag, multiplied at full precision.
module fusion_unit #(
  parameter int OUT_W = 52
) (
  input  logic [7:0]       act,
  input  logic [7:0]       wgt,
  input  logic [3:0]       in_width,
  input  logic [3:0]       weight_width,
  input  logic             s_in,
  input  logic             s_weight,
  output logic [OUT_W-1:0] prod
);
  function automatic logic signed [8:0] operand(input logic [7:0] v, input logic [3:0] width,
                                                input logic sgn);
    logic signed [8:0] r;
    case (width)
      4'd2:    r = {{7{sgn & v[1]}}, v[1:0]};
      4'd4:    r = {{5{sgn & v[3]}}, v[3:0]};
      default: r = {sgn & v[7], v};
    endcase
    return r;
  endfunction

  logic signed [17:0] p;

  always_comb begin
    p    = operand(act, in_width, s_in) * operand(wgt, weight_width, s_weight);
    prod = {{(OUT_W-18){p[17]}}, p};
  end
endmodule

module fusion_array_stream #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int LOG_ROWS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  in_width,
  input  logic [3:0]                  weight_width,
  input  logic                        s_in,
  input  logic                        s_weight,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [COLS*8-1:0]           w_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ROWS*8-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COLS*4*(10+LOG_ROWS)-1:0] out_data,
  output logic                        out_last,
  output logic                        busy
);
  localparam int COL_WIDTH = 10 + LOG_ROWS;
  localparam int PSUM_W    = 4 * COL_WIDTH;
  localparam int VEC_W     = COLS * PSUM_W;

  typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} state_t;

  state_t              state;
  logic [LOG_ROWS-1:0] row_cnt;
  logic [3:0]          cfg_in_width;
  logic [3:0]          cfg_weight_width;
  logic                cfg_s_in;
  logic                cfg_s_weight;
  logic [7:0]          weights [ROWS][COLS];

  logic                stall;
  logic                accept;
  logic [7:0]          row_act [ROWS];
  logic [VEC_W-1:0]    psum_r  [ROWS];
  logic                valid_r [ROWS];
  logic                last_r  [ROWS];

  // stall freezes every pipeline register so nothing is dropped or duplicated
  assign stall    = out_valid && !out_ready;
  assign in_ready = (state == COMPUTE) && !stall;
  assign w_ready  = (state == LOAD_W);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      row_cnt          <= '0;
      cfg_in_width     <= 4'd0;
      cfg_weight_width <= 4'd0;
      cfg_s_in         <= 1'b0;
      cfg_s_weight     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_in_width     <= in_width;
            cfg_weight_width <= weight_width;
            cfg_s_in         <= s_in;
            cfg_s_weight     <= s_weight;
            row_cnt          <= '0;
            state            <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_valid) begin
            row_cnt <= row_cnt + LOG_ROWS'(1);
            if (row_cnt == LOG_ROWS'(ROWS - 1)) begin
              state <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (accept && in_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          weights[i][j] <= 8'd0;
        end
      end
    end else if (state == LOAD_W && w_valid) begin
      for (int j = 0; j < COLS; j++) begin
        weights[row_cnt][j] <= w_data[j*8 +: 8];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [VEC_W-1:0] prev_psum;
    logic [VEC_W-1:0] prod_row;
    logic [VEC_W-1:0] psum_q;
    logic             valid_q;
    logic             last_q;

    if (r == 0) begin : g_head
      assign row_act[0] = in_data[7:0];
      assign prev_psum  = '0;
    end else begin : g_skew
      // row r sees its lane r cycles late so it meets the psum from row r-1
      logic [7:0] sr [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < r; k++) sr[k] <= 8'd0;
        end else if (!stall) begin
          sr[0] <= in_data[r*8 +: 8];
          for (int k = 1; k < r; k++) sr[k] <= sr[k-1];
        end
      end
      assign row_act[r] = sr[r-1];
      assign prev_psum  = psum_r[r-1];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
      fusion_unit #(.OUT_W(PSUM_W)) u_pe (
        .act          (row_act[r]),
        .wgt          (weights[r][c]),
        .in_width     (cfg_in_width),
        .weight_width (cfg_weight_width),
        .s_in         (cfg_s_in),
        .s_weight     (cfg_s_weight),
        .prod         (prod_row[c*PSUM_W +: PSUM_W])
      );
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        psum_q  <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (!stall) begin
        for (int c = 0; c < COLS; c++) begin
          psum_q[c*PSUM_W +: PSUM_W] <= prev_psum[c*PSUM_W +: PSUM_W] + prod_row[c*PSUM_W +: PSUM_W];
        end
        if (r == 0) begin
          valid_q <= accept;
          last_q  <= accept && in_last;
        end else begin
          valid_q <= valid_r[r-1];
          last_q  <= last_r[r-1];
        end
      end
    end

    assign psum_r[r]  = psum_q;
    assign valid_r[r] = valid_q;
    assign last_r[r]  = last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= valid_r[ROWS-1];
      out_last  <= last_r[ROWS-1];
      out_data  <= psum_r[ROWS-1];
    end
  end
endmodule

// File: tb/tb_fusion_array_stream.sv
// Self-checking bench for fusion_array_stream: constant table jobs, corner sequences and
// randomized jobs scored against an arithmetic dot-product model.
module tb_fusion_array_stream;
  localparam int ROWS = 8, COLS = 8, LOG_ROWS = 3;
  localparam int PSUM_W = 4 * (10 + LOG_ROWS);
  localparam int VEC_W = COLS * PSUM_W;

  logic clk, rst, start, s_in, s_weight, w_valid, w_ready, in_valid, in_ready, in_last;
  logic out_valid, out_ready, out_last, busy;
  logic [3:0] in_width, weight_width;
  logic [COLS*8-1:0] w_data;
  logic [ROWS*8-1:0] in_data;
  logic [VEC_W-1:0] out_data;

  fusion_array_stream #(.ROWS(ROWS), .COLS(COLS), .LOG_ROWS(LOG_ROWS)) dut (
    .clk(clk), .rst(rst), .start(start), .in_width(in_width), .weight_width(weight_width),
    .s_in(s_in), .s_weight(s_weight), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passed = 0;
  int out_cnt = 0, last_hs_cyc = 0, fall_cyc = 0;
  bit lat_chk = 1'b1, busy_q = 1'b0;
  logic [VEC_W-1:0] last_out;

  // model state: weights and the cfg the bench latched when it issued start
  logic [7:0] wm [ROWS][COLS];
  int m_iw = 8, m_ww = 8;
  bit m_si = 1'b0, m_sw = 1'b0;

  typedef struct { logic [VEC_W-1:0] data; bit last; int cyc; } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic int opv(input logic [7:0] b, input int width, input bit sgn);
    int wd, v;
    wd = (width == 2) ? 2 : (width == 4) ? 4 : 8;
    v = int'(b) % (1 << wd);
    if (sgn && v >= (1 << (wd - 1))) v = v - (1 << wd);
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] model(input logic [ROWS*8-1:0] acts);
    logic [VEC_W-1:0] r;
    longint s;
    for (int j = 0; j < COLS; j++) begin
      s = 0;
      for (int i = 0; i < ROWS; i++)
        s += longint'(opv(acts[i*8 +: 8], m_iw, m_si)) * longint'(opv(wm[i][j], m_ww, m_sw));
      r[j*PSUM_W +: PSUM_W] = s[PSUM_W-1:0];
    end
    return r;
  endfunction

  function automatic longint colv(input logic [VEC_W-1:0] v, input int j);
    logic [PSUM_W-1:0] c;
    c = v[j*PSUM_W +: PSUM_W];
    return longint'($signed(c));
  endfunction

  function automatic logic [ROWS*8-1:0] rand_vec();
    logic [ROWS*8-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  // scoreboard: score output handshakes, record accepted vectors, track busy falling
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        exp_t e;
        out_cnt++;
        last_out = out_data;
        if (out_last) last_hs_cyc = cyc;
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
          if (lat_chk) chk("latency", cyc - e.cyc, 9);
        end
      end
      if (in_valid && in_ready) q.push_back('{model(in_data), in_last, cyc});
      if (busy_q && !busy) fall_cyc = cyc;
      busy_q = busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int iw, input int ww, input bit si, input bit sw);
    int t;
    m_iw = iw; m_ww = ww; m_si = si; m_sw = sw;
    in_width = 4'(iw); weight_width = 4'(ww); s_in = si; s_weight = sw;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      w_valid = 1'b1;
      for (int j = 0; j < COLS; j++) w_data[j*8 +: 8] = wm[r][j];
      t = 0;
      @(negedge clk);
      while (!w_ready && t < 50) begin @(negedge clk); t++; end
      if (!w_ready) chk("w_ready_timeout", w_ready, 1);
      step();
    end
    w_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [ROWS*8-1:0] v, input bit last);
    int t;
    in_valid = 1'b1; in_data = v; in_last = last;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    step();
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    idle_in();
    t = 0;
    @(negedge clk);
    while (busy && t < 1000) begin @(negedge clk); t++; end
    if (busy) chk("idle_timeout", busy, 0);
    chk("queue_drained", q.size(), 0);
    step();
  endtask

  typedef struct {
    int iw; int ww; bit si; bit sw;
    logic [7:0] wfill; logic [7:0] afill; longint expv;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [ROWS*8-1:0] v;
    int base;

    tbl[0] = '{8, 8, 1'b1, 1'b1, 8'hFF, 8'd127, -64'sd1016};
    tbl[1] = '{8, 8, 1'b0, 1'b0, 8'hFF, 8'd127, 64'sd259080};
    tbl[2] = '{4, 4, 1'b1, 1'b1, 8'hFF, 8'h07, -64'sd56};
    tbl[3] = '{2, 2, 1'b0, 1'b0, 8'hFF, 8'h06, 64'sd48};
    tbl[4] = '{8, 2, 1'b1, 1'b1, 8'h02, 8'h80, 64'sd2048};
    tbl[5] = '{8, 8, 1'b1, 1'b1, 8'h80, 8'h80, 64'sd131072};

    rst = 1'b1; start = 1'b0; in_width = 4'd8; weight_width = 4'd8; s_in = 1'b0; s_weight = 1'b0;
    w_valid = 1'b0; w_data = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    step();

    // identity: single-vector job, column j = j+1 with 9-cycle latency
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) wm[i][j] = (i == j) ? 8'd1 : 8'd0;
    start_job(8, 8, 1'b1, 1'b1);
    for (int i = 0; i < ROWS; i++) v[i*8 +: 8] = 8'(i + 1);
    send_vec(v, 1'b1);
    wait_idle();
    for (int j = 0; j < COLS; j++) chk("identity_col", colv(last_out, j), j + 1);

    // constant table of uniform-fill jobs
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) wm[i][j] = tbl[k].wfill;
      start_job(tbl[k].iw, tbl[k].ww, tbl[k].si, tbl[k].sw);
      for (int i = 0; i < ROWS; i++) v[i*8 +: 8] = tbl[k].afill;
      send_vec(v, 1'b1);
      wait_idle();
      for (int j = 0; j < COLS; j++) chk($sformatf("table%0d_col%0d", k, j), colv(last_out, j), tbl[k].expv);
    end

    // backpressure: 20 back-to-back vectors with out_ready low for 5 cycles
    lat_chk = 1'b0;
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) wm[i][j] = 8'($urandom);
    start_job(8, 8, 1'b1, 1'b1);
    base = out_cnt;
    fork
      begin
        for (int k = 0; k < 20; k++) send_vec(rand_vec(), k == 19);
        idle_in();
      end
      begin
        repeat (12) step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_count", out_cnt - base, 20);
    chk("bp_busy_fall", fall_cyc - last_hs_cyc, 1);

    // bubbles: in_valid toggles, each output 9 cycles after its own acceptance
    lat_chk = 1'b1;
    start_job(4, 8, 1'b0, 1'b1);
    base = out_cnt;
    for (int k = 0; k < 10; k++) begin
      send_vec(rand_vec(), k == 9);
      idle_in();
      step();
    end
    wait_idle();
    chk("bubble_count", out_cnt - base, 10);

    // reset mid-COMPUTE with 4 vectors in flight
    start_job(8, 8, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_vec(rand_vec(), 1'b0);
    idle_in();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    q.delete();
    rst = 1'b0;
    base = out_cnt;
    repeat (20) step();
    chk("rst_mid_no_output", out_cnt - base, 0);

    // fresh job after the abort; start and cfg changes during COMPUTE are ignored
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) wm[i][j] = 8'($urandom);
    start_job(8, 8, 1'b0, 1'b0);
    base = out_cnt;
    for (int k = 0; k < 3; k++) send_vec(rand_vec(), 1'b0);
    start = 1'b1; in_width = 4'd4; weight_width = 4'd2; s_in = 1'b1; s_weight = 1'b1;
    for (int k = 0; k < 3; k++) send_vec(rand_vec(), 1'b0);
    start = 1'b0;
    send_vec(rand_vec(), 1'b1);
    wait_idle();
    chk("ignore_start_count", out_cnt - base, 7);
    repeat (3) step();
    chk("ignore_start_idle", busy, 0);

    // randomized jobs with random gaps and random backpressure
    lat_chk = 1'b0;
    for (int jb = 0; jb < 4; jb++) begin
      int modes [3];
      modes = '{2, 4, 8};
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) wm[i][j] = 8'($urandom);
      start_job(modes[$urandom_range(0, 2)], modes[$urandom_range(0, 2)],
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      base = out_cnt;
      fork
        begin
          for (int k = 0; k < 8; k++) begin
            send_vec(rand_vec(), k == 7);
            idle_in();
            if ($urandom_range(0, 1) == 1) step();
          end
        end
        begin
          repeat (30) begin out_ready = 1'($urandom_range(0, 1)); step(); end
          out_ready = 1'b1;
        end
      join
      wait_idle();
      chk("rand_count", out_cnt - base, 8);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
